// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier with sign handling by magnitude/negate
// and an optional single-cycle path for zero operands.
//
// state | meaning
// IDLE  | waiting for Start; operands captured on accept
// RUN   | one add/shift iteration per cycle, BITS cycles
// FIX   | form final product, negate if operand signs differ
// ZSKIP | zero operand seen at accept, product is 0
// DONE  | publish Producto with a one-cycle Ready pulse
module seq_multiplier #(
  parameter int BITS      = 8,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Signed,
  input  logic [BITS-1:0]   Multiplicando,
  input  logic [BITS-1:0]   Multiplicador,
  output logic [2*BITS-1:0] Producto,
  output logic              Ready,
  output logic              Busy
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZSKIP} state_t;

  state_t            state_q, state_d;
  logic [BITS:0]     a_q, a_d;
  logic [BITS-1:0]   q_q, q_d;
  logic [BITS-1:0]   m_q, m_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              signed_q, signed_d;
  logic              sb_q, sb_d;
  logic              sq_q, sq_d;
  logic [2*BITS-1:0] res_q, res_d;
  logic [2*BITS-1:0] prod_q, prod_d;
  logic              ready_q, ready_d;

  logic              neg_b, neg_q;
  logic [BITS-1:0]   mag_b, mag_q;
  logic [BITS:0]     sum;
  logic [2*BITS:0]   shifted;
  logic [2*BITS-1:0] mag_p;

  assign neg_b   = Signed & Multiplicando[BITS-1];
  assign neg_q   = Signed & Multiplicador[BITS-1];
  // The most-negative operand negates to itself, which read unsigned is 2^(BITS-1).
  assign mag_b   = neg_b ? -Multiplicando : Multiplicando;
  assign mag_q   = neg_q ? -Multiplicador : Multiplicador;
  assign sum     = a_q + (q_q[0] ? {1'b0, m_q} : '0);
  assign shifted = {sum, q_q} >> 1;
  assign mag_p   = {a_q[BITS-1:0], q_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    sb_d     = sb_q;
    sq_d     = sq_q;
    res_d    = res_q;
    prod_d   = prod_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          signed_d = Signed;
          sb_d     = neg_b;
          sq_d     = neg_q;
          m_d      = mag_b;
          q_d      = mag_q;
          a_d      = '0;
          cnt_d    = CW'(BITS);
          if ((SKIP_ZERO != 0) && ((Multiplicando == '0) || (Multiplicador == '0)))
            state_d = ZSKIP;
          else
            state_d = RUN;
        end
      end
      RUN: begin
        a_d   = shifted[2*BITS:BITS];
        q_d   = shifted[BITS-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        res_d   = (signed_q & (sb_q ^ sq_q)) ? -mag_p : mag_p;
        state_d = DONE;
      end
      ZSKIP: begin
        res_d   = '0;
        state_d = DONE;
      end
      DONE: begin
        // Producto and Ready move on the same edge so a consumer never sees a stale product.
        prod_d  = res_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      sb_q     <= 1'b0;
      sq_q     <= 1'b0;
      res_q    <= '0;
      prod_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      sb_q     <= sb_d;
      sq_q     <= sq_d;
      res_q    <= res_d;
      prod_q   <= prod_d;
      ready_q  <= ready_d;
    end
  end

  assign Producto = prod_q;
  assign Ready    = ready_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed BITS=8 scenarios plus
// reference-model sweeps at BITS=4 (exhaustive) and BITS=16 (random).
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  b8 = '0, q8 = '0;
  logic [15:0] p8;
  logic        rdy8, busy8;

  logic        st4 = 1'b0, sg4 = 1'b0;
  logic [3:0]  b4 = '0, q4 = '0;
  logic [7:0]  p4;
  logic        rdy4, busy4;

  logic        st16 = 1'b0, sg16 = 1'b0;
  logic [15:0] b16 = '0, q16 = '0;
  logic [31:0] p16;
  logic        rdy16, busy16;

  seq_multiplier #(.BITS(8), .SKIP_ZERO(1)) dut8 (
    .clk(clk), .rst(rst), .Start(st8), .Signed(sg8), .Multiplicando(b8),
    .Multiplicador(q8), .Producto(p8), .Ready(rdy8), .Busy(busy8));

  seq_multiplier #(.BITS(4), .SKIP_ZERO(0)) dut4 (
    .clk(clk), .rst(rst), .Start(st4), .Signed(sg4), .Multiplicando(b4),
    .Multiplicador(q4), .Producto(p4), .Ready(rdy4), .Busy(busy4));

  seq_multiplier #(.BITS(16), .SKIP_ZERO(0)) dut16 (
    .clk(clk), .rst(rst), .Start(st16), .Signed(sg16), .Multiplicando(b16),
    .Multiplicador(q16), .Producto(p16), .Ready(rdy16), .Busy(busy16));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb8[$];
  logic [31:0] sb4[$];
  logic [31:0] sb16[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitors: every Ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdy8) begin
      if (sb8.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb8_unexpected_ready: got Producto=%0h expected no Ready", p8);
      end else chk("sb8_product", 32'(p8), sb8.pop_front());
    end
    if (rdy4) begin
      if (sb4.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb4_unexpected_ready: got Producto=%0h expected no Ready", p4);
      end else chk("sb4_product", 32'(p4), sb4.pop_front());
    end
    if (rdy16) begin
      if (sb16.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb16_unexpected_ready: got Producto=%0h expected no Ready", p16);
      end else chk("sb16_product", p16, sb16.pop_front());
    end
  end

  task automatic op8(input logic [7:0] b, input logic [7:0] q, input logic s,
                     input logic [15:0] exp, input int lat, input bit disturb);
    int  n;
    bit  found;
    bit  busy_ok;
    @(negedge clk);
    b8 = b; q8 = q; sg8 = s; st8 = 1'b1;
    sb8.push_back(32'(exp));
    @(posedge clk); #1;
    chk("op8_busy_after_accept", 32'(busy8), 32'd1);
    @(negedge clk); st8 = 1'b0;
    n = 0; found = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (rdy8) begin found = 1'b1; break; end
      if (!busy8) busy_ok = 1'b0;
      if (disturb) begin
        if (n < lat - 3) begin
          st8 = ~st8; b8 = 8'($urandom); q8 = 8'($urandom); sg8 = ~sg8;
        end else st8 = 1'b0;
      end
    end
    chk("op8_ready_latency", found ? n : 999, lat);
    chk("op8_busy_until_ready", 32'(busy_ok), 32'd1);
    chk("op8_busy_low_at_ready", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    chk("op8_ready_one_cycle", 32'(rdy8), 32'd0);
    chk("op8_idle_after", 32'(busy8), 32'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib, p, n;
    bit found;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    @(negedge clk);
    b4 = a; q4 = b; sg4 = s; st4 = 1'b1;
    sb4.push_back(32'(p[7:0]));
    @(posedge clk);
    @(negedge clk); st4 = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n++;
      if (rdy4) begin found = 1'b1; break; end
    end
    chk("run4_ready_latency", found ? n : 999, 6);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint ia, ib;
    logic [63:0] p;
    int n;
    bit found;
    ia = s ? longint'($signed(a)) : longint'(a);
    ib = s ? longint'($signed(b)) : longint'(b);
    p  = ia * ib;
    @(negedge clk);
    b16 = a; q16 = b; sg16 = s; st16 = 1'b1;
    sb16.push_back(p[31:0]);
    @(posedge clk);
    @(negedge clk); st16 = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (rdy16) begin found = 1'b1; break; end
    end
    chk("run16_ready_latency", found ? n : 999, 18);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rt[3];
    int nr, cyc;
    bit prev_rdy;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_p8", 32'(p8), 32'd0);
    chk("reset_rdy8", 32'(rdy8), 32'd0);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_p4", 32'(p4), 32'd0);
    chk("reset_p16", p16, 32'd0);
    @(negedge clk); rst = 1'b1;

    op8(8'd13, 8'd11, 1'b0, 16'h008F, 10, 1'b0);
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 10, 1'b0);
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 10, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 10, 1'b0);
    op8(8'h05, 8'h03, 1'b1, 16'h000F, 10, 1'b0);
    op8(8'h7F, 8'h81, 1'b1, 16'hC0FF, 10, 1'b0);
    op8(8'h80, 8'h02, 1'b0, 16'h0100, 10, 1'b0);
    op8(8'h00, 8'd77, 1'b0, 16'h0000, 2, 1'b0);
    op8(8'd13, 8'd11, 1'b0, 16'h008F, 10, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 10, 1'b0);

    // Abort a 13 x 11 at E5 with an asynchronous reset.
    @(negedge clk);
    b8 = 8'd13; q8 = 8'd11; sg8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    @(negedge clk); st8 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_p8", 32'(p8), 32'd0);
    chk("abort_rdy8", 32'(rdy8), 32'd0);
    chk("abort_busy8", 32'(busy8), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    op8(8'd6, 8'd7, 1'b0, 16'h002A, 10, 1'b0);

    // Start held high: three back-to-back operations.
    @(negedge clk);
    b8 = 8'd3; q8 = 8'd4; sg8 = 1'b0; st8 = 1'b1;
    repeat (3) sb8.push_back(32'd12);
    nr = 0; cyc = 0; prev_rdy = 1'b0;
    for (int i = 0; i < 60 && nr < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_rdy) chk("held_busy_after_idle", 32'(busy8), 32'd1);
      prev_rdy = 1'b0;
      if (rdy8) begin
        rt[nr] = cyc;
        nr++;
        chk("held_busy_low_at_ready", 32'(busy8), 32'd0);
        prev_rdy = (nr < 3);
        if (nr == 3) st8 = 1'b0;
      end
    end
    st8 = 1'b0;
    chk("held_ready_count", nr, 3);
    if (nr == 3) begin
      chk("held_first_ready", rt[0], 11);
      chk("held_gap1", rt[1] - rt[0], 11);
      chk("held_gap2", rt[2] - rt[1], 11);
    end
    @(posedge clk); #1;
    chk("held_no_fourth_op", 32'(busy8), 32'd0);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run4(4'(a), 4'(b), s[0]);

    run16(16'hFFFF, 16'hFFFF, 1'b0);
    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'h0000, 16'h1234, 1'b1);
    for (int i = 0; i < 2000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    repeat (4) @(posedge clk);
    #1;
    chk("sb8_drained", sb8.size(), 0);
    chk("sb4_drained", sb4.size(), 0);
    chk("sb16_drained", sb16.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
